ring_frame_reader: RTL and testbench
====================================

// Module: ring_frame_reader
// PURPOSE
//  Read-side consumer for ring_buffer_64. Drains framed bytes (rd_first/rd_last tags) via rd_en.
//  Re-presents each frame downstream as a valid/ready byte stream with first/last markers.
//  Enforces a max frame length, drops orphan bytes, and inserts an inter-frame gap.
//  Sits between the packet buffer and the UDP/MAC transmit path; single clock domain (buffer rd_clk).
// PARAMETERS
//  MAX_LEN  64  max bytes per frame; longer frames are truncated (range 2..255)
//  IFG      4   idle cycles after each emitted last byte before next read (0..15)
// PORTS
//  clk        in   1  clock (buffer rd_clk)
//  reset      in   1  synchronous, active-high reset
//  empty      in   1  buffer empty
//  rddata     in   8  buffer data, valid the cycle after rd_en
//  rd_first   in   1  tag: byte is frame start, same timing as rddata
//  rd_last    in   1  tag: byte is frame end, same timing as rddata
//  rd_en      out  1  read strobe to buffer, one byte per pulse
//  out_data   out  8  downstream byte
//  out_valid  out  1  out_data valid
//  out_first  out  1  first byte of frame, qualified by out_valid
//  out_last   out  1  last byte of frame, qualified by out_valid
//  out_ready  in   1  downstream accept; transfer = out_valid & out_ready
//  frame_err  out  1  one-cycle pulse on truncation or unterminated frame
//  frame_cnt  out  16 frames completed (saturating)
//  drop_cnt   out  16 bytes discarded (saturating)
// BEHAVIOUR
//  Reset: rd_en=0, out_valid=0, out_data=0, out_first=0, out_last=0, frame_err=0, counters=0, state=IDLE.
//   Reset mid-read discards the in-flight byte (lost from buffer, not counted).
//  Read issue: rd_en=1 iff state in {IDLE,FRAME,DISCARD} & !empty & !inflight & (!out_valid | out_ready).
//   inflight = rd_en registered. Byte is captured the cycle after rd_en. Peak rate 1 byte / 2 clk.
//  Holding reg: captured byte sets out_valid; held stable until transfer; out_valid drops after transfer unless new byte lands.
//  len: 8-bit byte count of current frame; cleared on any accepted rd_first.
//  FSM, evaluated on each captured byte:
//   IDLE:    rd_first=1 -> emit out_first=1, len=1; if rd_last also set -> single-byte frame, emit out_last=1, ->GAP on its transfer; else ->FRAME.
//            rd_first=0 -> discard, drop_cnt++, stay IDLE.
//   FRAME:   rd_first=1 -> frame_err pulse, byte starts new frame (as IDLE rule).
//            rd_last=1 -> emit out_last=1, ->GAP on transfer, frame_cnt++ on transfer.
//            len+1==MAX_LEN & !rd_last -> emit with out_last=1, frame_err pulse, frame_cnt++ on transfer, ->DISCARD.
//            otherwise emit, len++.
//   DISCARD: rd_first=1 -> start new frame (IDLE rule, no gap); else drop_cnt++; rd_last=1 -> ->GAP.
//   GAP:     rd_en=0; counts IFG cycles, then ->IDLE (IFG=0: ->IDLE next cycle).
//  GAP entry from FRAME occurs on the out_last transfer cycle, not on capture.
//  Flags out_first/out_last change only when a new byte is captured.
//  frame_err asserts in the capture cycle of the offending byte.
//  Counters saturate at 16'hFFFF.
//  empty rising between reads: rd_en stays low, no effect on held byte.
//  out_ready low for any length: no reads issued while the holding reg is full, no data lost.
// TESTING
//  1 Buffer frame {17,8,100,42}, first on 17, last on 42, out_ready=1 -> out bytes 17(first),8,100,42(last); frame_cnt=1; rd_en idle 4 clk after.
//  2 Single byte 8'hA5 with first&last -> one transfer, out_first=out_last=1; frame_cnt=1.
//  3 Orphans {3,4} without first, then frame {9(first),10(last)} -> drop_cnt=2; outputs 9,10 only.
//  4 MAX_LEN=4, frame of 6 bytes 1..6 -> out 1..4, 4 has out_last, frame_err=1 once; drop_cnt=2; frame_cnt=1.
//  5 out_ready held low 10 clk mid-frame -> out_data stable, at most 1 rd_en pulse; all bytes in order after release.
//  6 reset pulsed during FRAME -> all outputs 0 next clk; next frame with rd_first is emitted normally.

Source files
------------

// File: rtl/ring_frame_reader_if.sv
// Buffer read side and downstream byte stream of ring_frame_reader.
// The slave modport is the reader. The master modport is the buffer plus the sink around it.
interface ring_frame_reader_if;
    logic        empty;
    logic [7:0]  rddata;
    logic        rd_first;
    logic        rd_last;
    logic        rd_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_first;
    logic        out_last;
    logic        out_ready;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    modport slave (
        input  empty, rddata, rd_first, rd_last, out_ready,
        output rd_en, out_data, out_valid, out_first, out_last,
        output frame_err, frame_cnt, drop_cnt
    );

    modport master (
        output empty, rddata, rd_first, rd_last, out_ready,
        input  rd_en, out_data, out_valid, out_first, out_last,
        input  frame_err, frame_cnt, drop_cnt
    );
endinterface

// File: rtl/ring_frame_reader.sv
// Drains tagged bytes from ring_buffer_64 and re-presents them as a valid/ready frame stream.
// Frames are length-limited, orphan bytes are dropped, and an idle gap follows each frame.
module ring_frame_reader #(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned IFG     = 4
) (
    input  logic               clk,
    input  logic               reset,
    ring_frame_reader_if.slave bus
);
    // LAST_WAIT holds off further reads until the last byte of a frame is accepted.
    typedef enum logic [2:0] {IDLE, FRAME, DISCARD, LAST_WAIT, GAP} state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [3:0] IFG_LAST  = (IFG == 0) ? 4'd0 : 4'(IFG - 1);

    state_t      state_r;
    logic        inflight_r;
    logic [7:0]  len_r;
    logic [3:0]  gap_cnt_r;
    logic [7:0]  out_data_r;
    logic        out_valid_r;
    logic        out_first_r;
    logic        out_last_r;
    logic        frame_err_r;
    logic [15:0] frame_cnt_r;
    logic [15:0] drop_cnt_r;
    logic        can_read_s;
    logic        rd_en_s;
    logic        xfer_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Read strobe and downstream transfer qualification.
    always_comb begin
        can_read_s = 1'b0;
        case (state_r)
            IDLE, FRAME, DISCARD: can_read_s = 1'b1;
            default:              can_read_s = 1'b0;
        endcase
        rd_en_s = can_read_s & ~bus.empty & ~inflight_r & (~out_valid_r | bus.out_ready);
        xfer_s  = out_valid_r & bus.out_ready;
    end

    // Frame FSM, holding register and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            inflight_r  <= 1'b0;
            len_r       <= 8'd0;
            gap_cnt_r   <= 4'd0;
            out_data_r  <= 8'd0;
            out_valid_r <= 1'b0;
            out_first_r <= 1'b0;
            out_last_r  <= 1'b0;
            frame_err_r <= 1'b0;
            frame_cnt_r <= 16'd0;
            drop_cnt_r  <= 16'd0;
        end else begin
            inflight_r  <= rd_en_s;
            frame_err_r <= 1'b0;

            if (xfer_s) begin
                out_valid_r <= 1'b0;
                if (out_last_r) begin
                    frame_cnt_r <= sat_inc(frame_cnt_r);
                end
                if (state_r == LAST_WAIT) begin
                    state_r   <= GAP;
                    gap_cnt_r <= 4'd0;
                end
            end

            if (state_r == GAP) begin
                if (gap_cnt_r == IFG_LAST) begin
                    state_r <= IDLE;
                end else begin
                    gap_cnt_r <= gap_cnt_r + 4'd1;
                end
            end

            // A read is only issued in IDLE/FRAME/DISCARD, and those states change only
            // here, so the state seen at capture is the state the read was issued in.
            if (inflight_r) begin
                case (state_r)
                    IDLE, DISCARD, FRAME: begin
                        if (bus.rd_first) begin
                            out_data_r  <= bus.rddata;
                            out_valid_r <= 1'b1;
                            out_first_r <= 1'b1;
                            out_last_r  <= bus.rd_last;
                            len_r       <= 8'd1;
                            state_r     <= bus.rd_last ? LAST_WAIT : FRAME;
                            if (state_r == FRAME) begin
                                frame_err_r <= 1'b1;
                            end
                        end else if (state_r != FRAME) begin
                            drop_cnt_r <= sat_inc(drop_cnt_r);
                            if (state_r == DISCARD && bus.rd_last) begin
                                state_r   <= GAP;
                                gap_cnt_r <= 4'd0;
                            end
                        end else if (bus.rd_last) begin
                            out_data_r  <= bus.rddata;
                            out_valid_r <= 1'b1;
                            out_first_r <= 1'b0;
                            out_last_r  <= 1'b1;
                            len_r       <= len_r + 8'd1;
                            state_r     <= LAST_WAIT;
                        end else if (len_r + 8'd1 == MAX_LEN_B) begin
                            out_data_r  <= bus.rddata;
                            out_valid_r <= 1'b1;
                            out_first_r <= 1'b0;
                            out_last_r  <= 1'b1;
                            frame_err_r <= 1'b1;
                            len_r       <= len_r + 8'd1;
                            state_r     <= DISCARD;
                        end else begin
                            out_data_r  <= bus.rddata;
                            out_valid_r <= 1'b1;
                            out_first_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            len_r       <= len_r + 8'd1;
                        end
                    end
                    default: begin
                        state_r <= state_r;
                    end
                endcase
            end
        end
    end

    assign bus.rd_en     = rd_en_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_first = out_first_r;
    assign bus.out_last  = out_last_r;
    assign bus.frame_err = frame_err_r;
    assign bus.frame_cnt = frame_cnt_r;
    assign bus.drop_cnt  = drop_cnt_r;
endmodule

// File: tb/tb_ring_frame_reader.sv
// Scoreboard bench for ring_frame_reader: a buffer model feeds tagged bytes and
// a monitor checks every downstream transfer against the queued expected bytes.
module tb_ring_frame_reader;
    typedef struct packed {
        logic       f;
        logic       l;
        logic [7:0] d;
    } bbyte_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   err_pulses = 0;
    int   gap_cnt = 0;
    int   gap_obs = -1;
    logic gap_meas = 1'b0;
    bbyte_t     bufq[$];
    logic [9:0] expq[$];
    bbyte_t     bb_pop;
    logic [9:0] exp_item;

    ring_frame_reader_if bus();

    ring_frame_reader #(.MAX_LEN(4), .IFG(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Buffer model: data and tags appear the cycle after rd_en.
    always @(posedge clk) begin
        if (bus.rd_en === 1'b1) begin
            bb_pop = bufq.pop_front();
            bus.rddata   <= bb_pop.d;
            bus.rd_first <= bb_pop.f;
            bus.rd_last  <= bb_pop.l;
        end
        bus.empty <= (bufq.size() == 0);
    end

    // Monitor: checks each transfer, counts frame_err pulses, measures the post-frame gap.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL xfer unexpected byte got %h first %b last %b",
                             bus.out_data, bus.out_first, bus.out_last);
                end else begin
                    exp_item = expq.pop_front();
                    if ({bus.out_data, bus.out_first, bus.out_last} !== exp_item) begin
                        errors++;
                        $display("FAIL xfer got data %h first %b last %b expected data %h first %b last %b",
                                 bus.out_data, bus.out_first, bus.out_last,
                                 exp_item[9:2], exp_item[1], exp_item[0]);
                    end
                end
                if (bus.out_last === 1'b1) begin
                    gap_meas = 1'b1;
                    gap_cnt  = 0;
                end
            end else if (gap_meas) begin
                if (bus.rd_en === 1'b1) begin
                    gap_obs  = gap_cnt;
                    gap_meas = 1'b0;
                end else begin
                    gap_cnt++;
                end
            end
            if (bus.frame_err === 1'b1) err_pulses++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic f, input logic l, input logic [7:0] d,
                        input logic emit, input logic ef, input logic el);
        bufq.push_back({f, l, d});
        if (emit) expq.push_back({d, ef, el});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bufq.size() == 0 && expq.size() == 0 && bus.out_valid === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        check(name, {31'd0, done}, 32'd1);
        repeat (8) tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"},     {31'd0, bus.rd_en},     32'd0);
        check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_out_data"},  {24'd0, bus.out_data},  32'd0);
        check({tag, "_flags"},     {29'd0, bus.out_first, bus.out_last, bus.frame_err}, 32'd0);
        check({tag, "_frame_cnt"}, {16'd0, bus.frame_cnt}, 32'd0);
        check({tag, "_drop_cnt"},  {16'd0, bus.drop_cnt},  32'd0);
    endtask

    initial begin
        logic       found;
        logic       stable;
        int         pulses;
        logic [7:0] held;

        reset = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;
        tick();

        // Four-byte frame followed by a single-byte frame; the gap between them is measured.
        push(1'b1, 1'b0, 8'd17,  1'b1, 1'b1, 1'b0);
        push(1'b0, 1'b0, 8'd8,   1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'd100, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b1, 8'd42,  1'b1, 1'b0, 1'b1);
        push(1'b1, 1'b1, 8'hA5,  1'b1, 1'b1, 1'b1);
        drain("drain_t1_t2");
        check("t1_gap_cycles", gap_obs, 32'd4);
        check("t2_frame_cnt", {16'd0, bus.frame_cnt}, 32'd2);
        check("t2_drop_cnt",  {16'd0, bus.drop_cnt},  32'd0);

        // Orphans before a frame start are dropped.
        push(1'b0, 1'b0, 8'd3,  1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'd4,  1'b0, 1'b0, 1'b0);
        push(1'b1, 1'b0, 8'd9,  1'b1, 1'b1, 1'b0);
        push(1'b0, 1'b1, 8'd10, 1'b1, 1'b0, 1'b1);
        drain("drain_t3");
        check("t3_drop_cnt",  {16'd0, bus.drop_cnt},  32'd2);
        check("t3_frame_cnt", {16'd0, bus.frame_cnt}, 32'd3);
        check("t3_no_err",    err_pulses, 32'd0);

        // Six-byte frame against MAX_LEN=4: truncated at byte 4, bytes 5 and 6 dropped.
        push(1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0);
        push(1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b1);
        push(1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0);
        drain("drain_t4");
        check("t4_err_pulses", err_pulses, 32'd1);
        check("t4_drop_cnt",   {16'd0, bus.drop_cnt},  32'd4);
        check("t4_frame_cnt",  {16'd0, bus.frame_cnt}, 32'd4);

        // Downstream stall of 10 cycles mid-frame.
        push(1'b1, 1'b0, 8'h31, 1'b1, 1'b1, 1'b0);
        push(1'b0, 1'b0, 8'h32, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b1, 8'h34, 1'b1, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.out_valid === 1'b1 && bus.out_data === 8'h32) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_reach_stall", {31'd0, found}, 32'd1);
        bus.out_ready = 1'b0;
        held   = bus.out_data;
        stable = 1'b1;
        pulses = 0;
        repeat (10) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_data !== held) stable = 1'b0;
            if (bus.rd_en === 1'b1) pulses++;
        end
        check("t5_held_stable", {31'd0, stable}, 32'd1);
        check("t5_rd_en_le1",   {31'd0, (pulses <= 1)}, 32'd1);
        bus.out_ready = 1'b1;
        drain("drain_t5");
        check("t5_frame_cnt", {16'd0, bus.frame_cnt}, 32'd5);

        // Reset while a frame is open, then a clean frame.
        push(1'b1, 1'b0, 8'h51, 1'b1, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (expq.size() == 0) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_open_frame", {31'd0, found}, 32'd1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check_zero("t6_reset");
        reset = 1'b0;
        push(1'b1, 1'b0, 8'h61, 1'b1, 1'b1, 1'b0);
        push(1'b0, 1'b1, 8'h62, 1'b1, 1'b0, 1'b1);
        drain("drain_t6");
        check("t6_frame_cnt",  {16'd0, bus.frame_cnt}, 32'd1);
        check("t6_drop_cnt",   {16'd0, bus.drop_cnt},  32'd0);
        check("final_err_pulses", err_pulses, 32'd1);
        check("final_exp_left", expq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
